data_mem_responder: RTL and testbench

- Memory-side responder for the core's load/store requests. It services the accesses the control unit issues in the MEM stage.
- Holds a word-addressed data RAM and accepts one request at a time over a valid/ready request channel.
- Inserts a configurable number of wait states, then returns read data or a completion status over a valid/ready response channel.
- Handles byte, half and word sizes, byte-lane stores and load sign/zero extension.

---
 rtl/data_mem_responder_if.sv | 26 ++
 rtl/data_mem_responder.sv | 187 ++++++++++++++++++
 tb/tb_data_mem_responder.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - request/response channel bundle between the core and the data memory responder
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  // core side: issues requests, consumes responses
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  // memory side: accepts requests, produces responses
  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - word RAM load/store responder with wait states; DMEM_ERR_EN enables access-fault detection
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus
);
  localparam int IDXW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic            access_err;
  logic [1:0]      eff_size;
  logic [IDXW+1:0] eff_addr;
  logic [IDXW-1:0] word_idx;
  logic [1:0]      lane;
  logic [3:0]      byte_en;
  logic [31:0]     wr_word;
  logic [31:0]     rd_word;
  logic [7:0]      rd_byte;
  logic [15:0]     rd_half;
  logic [31:0]     load_data;
  logic            commit;
  logic            mem_we;

`ifndef DMEM_ERR_EN
  // upper address bits are discarded when out-of-range indices wrap
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_q[31:IDXW+2];
`endif

  // decode the latched request into RAM index, lane enables and extended load data
  always_comb begin
`ifdef DMEM_ERR_EN
    access_err = (size_q == 2'b11)
              || (size_q == 2'b01 && addr_q[0])
              || (size_q == 2'b10 && addr_q[1:0] != 2'b00)
              || (|addr_q[31:IDXW+2]);
    eff_size   = size_q;
    eff_addr   = addr_q[IDXW+1:0];
`else
    access_err = 1'b0;
    eff_size   = (size_q == 2'b11) ? 2'b10 : size_q;
    eff_addr   = addr_q[IDXW+1:0];
    if (eff_size == 2'b01) eff_addr[0] = 1'b0;
    if (eff_size == 2'b10) eff_addr[1:0] = 2'b00;
`endif
    word_idx = eff_addr[IDXW+1:2];
    lane     = eff_addr[1:0];
    rd_word  = mem[word_idx];
    rd_byte  = rd_word[{lane, 3'b000} +: 8];
    rd_half  = rd_word[{lane[1], 4'b0000} +: 16];
    case (eff_size)
      2'b00: begin
        byte_en   = 4'b0001 << lane;
        wr_word   = {4{wdata_q[7:0]}};
        load_data = uns_q ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      end
      2'b01: begin
        byte_en   = 4'b0011 << {lane[1], 1'b0};
        wr_word   = {2{wdata_q[15:0]}};
        load_data = uns_q ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
      end
      default: begin
        byte_en   = 4'b1111;
        wr_word   = wdata_q;
        load_data = rd_word;
      end
    endcase
    commit = (state_q == ST_WAIT) && (cnt_q == 4'(WAIT_CYCLES));
    mem_we = commit && we_q && !access_err;
  end

  // store commit on the edge that enters RESP; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= wr_word[8*b +: 8];
      end
    end
  end

  // next-state logic: WAIT lasts one decode cycle plus WAIT_CYCLES wait states
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          we_d        = bus.req_we;
          size_d      = bus.req_size;
          uns_d       = bus.req_unsigned;
          addr_d      = bus.req_addr;
          wdata_d     = bus.req_wdata;
          cnt_d       = 4'd0;
          req_ready_d = 1'b0;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (commit) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = (we_q || access_err) ? 32'h0 : load_data;
          rsp_err_d   = access_err;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = 32'h0;
          rsp_err_d   = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = 32'h0;
        rsp_err_d   = 1'b0;
      end
    endcase
  end

  // FSM and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - randomized and directed bench for data_mem_responder with a byte-level memory model
module tb_data_mem_responder;
  localparam int DEPTH = 1024;
  localparam int W     = 1;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  data_mem_responder_if bus ();

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mm [DEPTH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // reference: memory as bytes, access size in bytes, extension by arithmetic
  function automatic void model(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] rd, output logic er);
    int nb;
    int idx;
    int off;
    logic [31:0] a;
    longint v;
`ifdef DMEM_ERR_EN
    er = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0)
      || (addr / 4 >= DEPTH);
    nb = (size == 2'd3) ? 4 : (1 << size);
    a  = addr;
`else
    er = 1'b0;
    nb = (size == 2'd3) ? 4 : (1 << size);
    a  = addr - addr % nb;
`endif
    rd = 32'h0;
    if (er) return;
    idx = int'((a / 4) % DEPTH);
    off = int'(a % 4);
    if (we) begin
      for (int i = 0; i < nb; i++) mm[idx][8*(off+i) +: 8] = wdata[8*i +: 8];
    end else begin
      v = 0;
      for (int i = 0; i < nb; i++) v = v + (longint'(mm[idx][8*(off+i) +: 8]) << (8*i));
      if (!uns && nb < 4 && v >= (longint'(1) << (8*nb - 1))) v = v - (longint'(1) << (8*nb));
      rd = v[31:0];
    end
  endfunction

  // one full transaction starting and ending at a falling edge
  task automatic xact(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input int stall, input bit poke);
    logic [31:0] erd;
    logic        eerr;
    int          c;
    model(we, size, uns, addr, wdata, erd, eerr);
    chk("idle_req_ready", bus.req_ready, 1);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    chk("busy_req_ready", bus.req_ready, 0);
    c = 0;
    while (bus.rsp_valid !== 1'b1 && c < 40) begin
      @(negedge clk);
      c++;
    end
    chk("latency", c, W + 1);
    for (int s = 0; s < stall; s++) begin
      chk("stall_valid", bus.rsp_valid, 1);
      chk("stall_rdata", bus.rsp_rdata, erd);
      chk("stall_req_ready", bus.req_ready, 0);
      bus.req_valid = poke;
      bus.req_we    = 1'b1;
      @(negedge clk);
      bus.req_valid = 1'b0;
    end
    chk("rsp_rdata", bus.rsp_rdata, erd);
    chk("rsp_err", bus.rsp_err, eerr);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("post_valid", bus.rsp_valid, 0);
    chk("post_rdata", bus.rsp_rdata, 0);
    chk("post_err", bus.rsp_err, 0);
    chk("post_req_ready", bus.req_ready, 1);
  endtask

  initial begin
    logic [31:0] a;
    checks           = 0;
    errors           = 0;
    reset            = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;
    bus.rsp_ready    = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_req_ready", bus.req_ready, 1);
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    chk("reset_rsp_rdata", bus.rsp_rdata, 0);
    chk("reset_rsp_err", bus.rsp_err, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 64; i++) xact(1'b1, 2'b10, 1'b0, 32'(i * 4), $urandom, 0, 1'b0);

    xact(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 0, 1'b0);
    xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, 1'b0);

    xact(1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF7F01, 0, 1'b0);
    xact(1'b0, 2'b00, 1'b0, 32'h12, 32'h0, 0, 1'b0);
    xact(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 0, 1'b0);
    xact(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 0, 1'b0);
    xact(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 0, 1'b0);

    xact(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, 0, 1'b0);
    xact(1'b1, 2'b00, 1'b0, 32'h21, 32'h000000AA, 0, 1'b0);
    xact(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 0, 1'b0);
    xact(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000BEEF, 0, 1'b0);
    xact(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 5, 1'b1);

    xact(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 0, 1'b0);
    xact(1'b1, 2'b10, 1'b0, 32'h1002, 32'hCAFEF00D, 0, 1'b0);
    xact(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 0, 1'b0);
    xact(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 0, 1'b0);
    xact(1'b0, 2'b11, 1'b0, 32'h24, 32'h0, 0, 1'b0);
    xact(1'b0, 2'b01, 1'b0, 32'h21, 32'h0, 0, 1'b0);

    chk("midreset_idle", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_size  = 2'b10;
    bus.req_addr  = 32'h30;
    bus.req_wdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("midreset_busy", bus.req_ready, 0);
    reset = 1'b1;
    #1;
    chk("midreset_req_ready", bus.req_ready, 1);
    chk("midreset_rsp_valid", bus.rsp_valid, 0);
    chk("midreset_rsp_rdata", bus.rsp_rdata, 0);
    chk("midreset_rsp_err", bus.rsp_err, 0);
    @(negedge clk);
    reset = 1'b0;
    xact(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 0, 1'b0);

    for (int n = 0; n < 200; n++) begin
      a = $urandom_range(0, 255);
      if ($urandom_range(0, 7) == 0) a = a + 32'h1000 * $urandom_range(1, 3);
      xact(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           a, $urandom, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
